serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller: sequences one full-adder cell, built from two half_adder

---
 rtl/serial_add_ctrl_pkg.sv | 28 ++
 rtl/serial_add_ctrl_fa_cell.sv | 58 +++++
 rtl/serial_add_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_pkg
//  Shared definitions for the bit-serial adder controller:
//   - STATE_W / state_t : FSM state width and encodings (IDLE=0, RUN=1, DONE=2)
//   - cnt_width()       : bit-counter width, ceil(log2(width)) with a floor of 1
// -----------------------------------------------------------------------------
package serial_add_ctrl_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ceil(log2(width)), never less than 1, so WIDTH=1 still gets a 1-bit
   // counter. Supports the legal operand range 1..32.
   function automatic int cnt_width(input int width);
      int w;
      w = 1;
      for (int i = 1; i < 6; i++) begin
         if ((1 << i) < width) w = i + 1;
      end
      return w;
   endfunction

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_add_ctrl_fa_cell.sv
// -----------------------------------------------------------------------------
// half_adder / fa_cell
//  Combinational datapath cell for the serial adder. fa_cell is a full adder
//  built from two half_adder instances plus an OR that merges their carries.
//
//  half_adder ports:
//   a, b  in  1   addend bits
//   s     out 1   a ^ b
//   c     out 1   a & b
//  fa_cell ports:
//   a, b  in  1   operand bits
//   cin   in  1   carry in
//   s     out 1   a ^ b ^ cin
//   cout  out 1   majority(a, b, cin)
// -----------------------------------------------------------------------------
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule : half_adder

module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic s0;
   logic c0;
   logic c1;

   // First stage adds the operand bits, second stage folds in the carry.
   half_adder u_ha0 (
      .a (a),
      .b (b),
      .s (s0),
      .c (c0)
   );

   half_adder u_ha1 (
      .a (s0),
      .b (cin),
      .s (s),
      .c (c1)
   );

   // At most one of the two half-adder carries can be set, so OR is exact.
   assign cout = c0 | c1;

endmodule : fa_cell

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//  Bit-serial adder controller. Runs one full-adder cell over WIDTH-bit
//  operands, LSB first, one bit per clock, and reports {cout,sum} = a + b.
//
//  Handshake: the requester raises start while busy=0; the controller accepts
//  it on that rising edge (capturing a and b) and raises busy. start is not
//  looked at again until the controller is back in IDLE, so there is no
//  queuing. done is a one-cycle pulse marking sum/cout valid; they then hold
//  until the next accepted request completes.
//
//  Ports:
//   clk        in  1        rising-edge clock
//   rst        in  1        synchronous active-high reset
//   start      in  1        request, sampled only in IDLE
//   a, b       in  WIDTH    operands, captured on the accepting edge
//   busy       out 1        1 in RUN and DONE
//   done       out 1        1 for the single DONE cycle
//   sum        out WIDTH    result, updated only on the RUN->DONE edge
//   cout       out 1        carry out of the MSB, updated with sum
//   state_dbg  out 2        current FSM state encoding
//
//  WIDTH legal range is 1..32.
// -----------------------------------------------------------------------------
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   sum,
   output logic               cout,
   output logic [STATE_W-1:0] state_dbg
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic             fa_s;
   logic             fa_c;
   logic [WIDTH-1:0] sum_shift;

   fa_cell u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the result
   // has walked down to sum_sr[0]. Written as shift/OR so WIDTH=1 needs no
   // special-cased slice.
   assign sum_shift = (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  sum_sr <= '0;
                  carry  <= 1'b0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= ST_RUN;
               end
            end

            ST_RUN: begin
               sum_sr <= sum_shift;
               carry  <= fa_c;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               // The last bit is processed on this edge: publish the result
               // straight from the next-state values so sum/cout change only
               // on the RUN->DONE edge.
               if (cnt == CNT_LAST) begin
                  sum   <= sum_shift;
                  cout  <= fa_c;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//  Bench for serial_add_ctrl at WIDTH = 1, 4 and 8 (instances 0, 1, 2).
//  Inputs change 1 time unit after the falling edge; the checker process
//  samples outputs on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start_v [3];
   logic [7:0] a_v     [3];
   logic [7:0] b_v     [3];

   logic       busy1, done1, cout1;
   logic [0:0] sum1;
   logic [1:0] st1;
   logic       busy4, done4, cout4;
   logic [3:0] sum4;
   logic [1:0] st4;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;
   logic [1:0] st8;

   serial_add_ctrl #(.WIDTH(1)) u_dut1 (
      .clk (clk), .rst (rst), .start (start_v[0]),
      .a (a_v[0][0:0]), .b (b_v[0][0:0]),
      .busy (busy1), .done (done1), .sum (sum1), .cout (cout1), .state_dbg (st1)
   );

   serial_add_ctrl #(.WIDTH(4)) u_dut4 (
      .clk (clk), .rst (rst), .start (start_v[1]),
      .a (a_v[1][3:0]), .b (b_v[1][3:0]),
      .busy (busy4), .done (done4), .sum (sum4), .cout (cout4), .state_dbg (st4)
   );

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (
      .clk (clk), .rst (rst), .start (start_v[2]),
      .a (a_v[2]), .b (b_v[2]),
      .busy (busy8), .done (done8), .sum (sum8), .cout (cout8), .state_dbg (st8)
   );

   int errors = 0;
   int checks = 0;
   logic [8:0] exp_q [$];
   bit mon_en = 1'b0;

   function automatic int w_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 4 : 8;
   endfunction

   // {cout,sum} zero-extended to 9 bits; equals a+b when correct.
   function automatic logic [8:0] res_of(input int i);
      case (i)
         0:       return {7'd0, cout1, sum1};
         1:       return {4'd0, cout4, sum4};
         default: return {cout8, sum8};
      endcase
   endfunction

   function automatic logic done_of(input int i);
      return (i == 0) ? done1 : (i == 1) ? done4 : done8;
   endfunction

   function automatic logic busy_of(input int i);
      return (i == 0) ? busy1 : (i == 1) ? busy4 : busy8;
   endfunction

   function automatic logic [1:0] st_of(input int i);
      return (i == 0) ? st1 : (i == 1) ? st4 : st8;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check_result(input string tag, input int i);
      if (exp_q.size() == 0) check({tag, "_queue_underflow"}, 32'd1, 32'd0);
      else check(tag, 32'(res_of(i)), 32'(exp_q.pop_front()));
   endtask

   // One full request on instance i: accept, scramble a/b during RUN, check
   // latency, result and return to idle.
   task automatic run_add(input int i, input logic [7:0] a, input logic [7:0] b);
      int w;
      int lat;
      logic [7:0] m;
      logic [7:0] am;
      logic [7:0] bm;
      w  = w_of(i);
      m  = 8'((9'd1 << w) - 9'd1);
      am = a & m;
      bm = b & m;
      exp_q.push_back({1'b0, am} + {1'b0, bm});
      start_v[i] = 1'b1;
      a_v[i] = am;
      b_v[i] = bm;
      tick();
      start_v[i] = 1'b0;
      lat = 1;
      check("busy_after_start", 32'(busy_of(i)), 32'd1);
      while (!done_of(i) && lat < w + 4) begin
         a_v[i] = 8'($urandom_range(0, 255));
         b_v[i] = 8'($urandom_range(0, 255));
         tick();
         lat++;
      end
      check("done_seen", 32'(done_of(i)), 32'd1);
      check("done_latency", 32'(lat), 32'(w + 1));
      check_result("sum_cout", i);
      tick();
      check("idle_after_done", {30'd0, busy_of(i), done_of(i)}, 32'd0);
   endtask

   // Continuous monitor: done never longer than one cycle, and the result
   // never moves except on the edge that raises done (or under reset).
   logic [8:0] prev_res  [3];
   logic       prev_done [3];
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (mon_en && !rst) begin
            if (done_of(i)) check("done_width", 32'(prev_done[i]), 32'd0);
            else check("sum_hold", 32'(res_of(i)), 32'(prev_res[i]));
         end
         prev_res[i]  = res_of(i);
         prev_done[i] = done_of(i);
      end
   end

   initial begin
      int n_done;
      int cyc;
      int last_done;

      // Reset for two cycles
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         a_v[i] = 8'd0;
         b_v[i] = 8'd0;
      end
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         check("rst_busy", 32'(busy_of(i)), 32'd0);
         check("rst_done", 32'(done_of(i)), 32'd0);
         check("rst_result", 32'(res_of(i)), 32'd0);
         check("rst_state", 32'(st_of(i)), 32'd0);
      end
      rst = 1'b0;
      tick();
      mon_en = 1'b1;

      // Directed WIDTH=4 operands
      run_add(1, 8'd3, 8'd5);
      run_add(1, 8'd15, 8'd1);
      run_add(1, 8'd15, 8'd15);
      run_add(1, 8'd0, 8'd0);

      // start held high: back-to-back adds every WIDTH+2 cycles
      n_done = 0;
      cyc = 0;
      last_done = -1;
      start_v[1] = 1'b1;
      a_v[1] = 8'd2;
      b_v[1] = 8'd3;
      exp_q.push_back(9'd5);
      while (n_done < 3 && cyc < 60) begin
         tick();
         cyc++;
         if (done_of(1)) begin
            check_result("held_sum", 1);
            if (last_done >= 0) check("held_spacing", 32'(cyc - last_done), 32'd6);
            last_done = cyc;
            n_done++;
            if (n_done == 3) start_v[1] = 1'b0;
         end
         if (!busy_of(1) && start_v[1]) exp_q.push_back(9'd5);
         if (busy_of(1) && !done_of(1)) begin
            a_v[1] = 8'($urandom_range(0, 15));
            b_v[1] = 8'($urandom_range(0, 15));
         end else begin
            a_v[1] = 8'd2;
            b_v[1] = 8'd3;
         end
      end
      check("held_done_count", 32'(n_done), 32'd3);
      tick();
      tick();
      check("held_idle", 32'(busy_of(1)), 32'd0);

      // Reset in RUN cycle 2 abandons the request
      start_v[1] = 1'b1;
      a_v[1] = 8'd9;
      b_v[1] = 8'd9;
      tick();
      start_v[1] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", 32'(busy_of(1)), 32'd0);
      check("abort_done", 32'(done_of(1)), 32'd0);
      check("abort_result", 32'(res_of(1)), 32'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("abort_no_done", 32'(done_of(1)), 32'd0);
      end
      run_add(1, 8'd9, 8'd9);

      // Width corners
      run_add(0, 8'd1, 8'd1);
      run_add(2, 8'd200, 8'd100);

      // Random operands per width
      for (int i = 0; i < 3; i++) begin
         for (int n = 0; n < 200; n++) begin
            run_add(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         end
      end

      tick();
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_serial_add_ctrl
